hwpe_stream_sink_2d: RTL and testbench

HWPE_STREAM_SINK_2D -- requirements
Module: hwpe_stream_sink_2d

---
 rtl/hwpe_stream_sink_2d.sv | 163 ++++++++++++++++
 tb/tb_hwpe_stream_sink_2d.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_sink_2d.sv
// 2D stream-to-TCDM sink: splits each stream beat into 32-bit lanes and writes them
// line by line. Optional stall counter enabled by defining HWPE_STREAM_SINK_PERF_EN.
module hwpe_stream_sink_2d #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned NB_TCDM_PORTS = DATA_WIDTH / 32,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic [31:0]                   base_addr_i,
  input  logic [CNT_WIDTH-1:0]          line_len_i,
  input  logic [31:0]                   line_stride_i,
  input  logic [CNT_WIDTH-1:0]          nb_lines_i,
  output logic                          ready_start_o,
  output logic                          busy_o,
  output logic                          done_o,
  input  logic                          stream_valid_i,
  output logic                          stream_ready_o,
  input  logic [DATA_WIDTH-1:0]         stream_data_i,
  input  logic [DATA_WIDTH/8-1:0]       stream_strb_i,
  output logic [NB_TCDM_PORTS-1:0]      tcdm_req_o,
  input  logic [NB_TCDM_PORTS-1:0]      tcdm_gnt_i,
  output logic [NB_TCDM_PORTS*32-1:0]   tcdm_add_o,
  output logic [NB_TCDM_PORTS-1:0]      tcdm_wen_o,
  output logic [NB_TCDM_PORTS*4-1:0]    tcdm_be_o,
  output logic [NB_TCDM_PORTS*32-1:0]   tcdm_data_o
`ifdef HWPE_STREAM_SINK_PERF_EN
  ,
  output logic [31:0]                   stall_cnt_o
`endif
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] WORKING = 1'b1;

  logic [0:0]               r_state;
  logic                     r_done;
  logic [NB_TCDM_PORTS-1:0] r_sent;
  logic [CNT_WIDTH-1:0]     r_line_len;
  logic [CNT_WIDTH-1:0]     r_nb_lines;
  logic [31:0]              r_line_stride;
  logic [31:0]              r_line_base;
  logic [CNT_WIDTH-1:0]     r_beat;
  logic [CNT_WIDTH-1:0]     r_line;

  logic                     w_working;
  logic                     w_empty;
  logic                     w_active;
  logic                     w_complete;
  logic                     w_last_beat;
  logic                     w_last_line;
  logic [31:0]              w_beat_off;
  logic [NB_TCDM_PORTS-1:0] w_req;
  logic [NB_TCDM_PORTS-1:0] w_lane_ok;

  assign w_working   = (r_state == WORKING);
  assign w_empty     = (r_line_len == '0) || (r_nb_lines == '0);
  assign w_active    = w_working && !w_empty;
  assign w_last_beat = (r_beat == r_line_len - CNT_WIDTH'(1));
  assign w_last_line = (r_line == r_nb_lines - CNT_WIDTH'(1));
  assign w_beat_off  = 32'(r_beat) * 32'(NB_TCDM_PORTS * 4);

  // A lane is satisfied once it was granted earlier, is granted now, or carries no bytes.
  always_comb begin
    w_req       = '0;
    w_lane_ok   = '0;
    tcdm_add_o  = '0;
    tcdm_be_o   = '0;
    tcdm_data_o = '0;
    for (int i = 0; i < int'(NB_TCDM_PORTS); i++) begin
      w_req[i]     = w_active && stream_valid_i && !r_sent[i] && (|stream_strb_i[4*i +: 4]);
      w_lane_ok[i] = r_sent[i] || (w_req[i] && tcdm_gnt_i[i]) || !(|stream_strb_i[4*i +: 4]);
      if (w_working) begin
        tcdm_add_o[32*i +: 32]  = r_line_base + w_beat_off + 32'(i * 4);
        tcdm_be_o[4*i +: 4]     = stream_strb_i[4*i +: 4];
        tcdm_data_o[32*i +: 32] = stream_data_i[32*i +: 32];
      end
    end
  end

  assign w_complete     = w_active && stream_valid_i && (&w_lane_ok);
  assign stream_ready_o = w_complete;
  assign tcdm_req_o     = w_req;
  assign tcdm_wen_o     = '0;
  assign ready_start_o  = (r_state == IDLE);
  assign busy_o         = w_working;
  assign done_o         = r_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_done        <= 1'b0;
      r_sent        <= '0;
      r_line_len    <= '0;
      r_nb_lines    <= '0;
      r_line_stride <= '0;
      r_line_base   <= '0;
      r_beat        <= '0;
      r_line        <= '0;
    end else if (clear_i) begin
      r_state       <= IDLE;
      r_done        <= 1'b0;
      r_sent        <= '0;
      r_line_len    <= '0;
      r_nb_lines    <= '0;
      r_line_stride <= '0;
      r_line_base   <= '0;
      r_beat        <= '0;
      r_line        <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start_i) begin
          r_state       <= WORKING;
          r_line_len    <= line_len_i;
          r_nb_lines    <= nb_lines_i;
          r_line_stride <= line_stride_i;
          r_line_base   <= base_addr_i;
          r_beat        <= '0;
          r_line        <= '0;
          r_sent        <= '0;
        end
      end else if (w_empty) begin
        r_state <= IDLE;
        r_done  <= 1'b1;
      end else if (w_complete) begin
        r_sent <= '0;
        if (w_last_beat) begin
          r_beat      <= '0;
          r_line_base <= r_line_base + r_line_stride;
          r_line      <= r_line + CNT_WIDTH'(1);
          if (w_last_line) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end else begin
          r_beat <= r_beat + CNT_WIDTH'(1);
        end
      end else begin
        r_sent <= r_sent | (w_req & tcdm_gnt_i);
      end
    end
  end

`ifdef HWPE_STREAM_SINK_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (clear_i || (ready_start_o && start_i)) begin
      r_stall_cnt <= '0;
    end else if (w_working && stream_valid_i && !stream_ready_o && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hwpe_stream_sink_2d.sv
// Scoreboard bench for hwpe_stream_sink_2d: expected lane writes are queued as beats
// are driven and popped as the TCDM side accepts them.
module tb_hwpe_stream_sink_2d;

  localparam int DW = 64;
  localparam int NP = 2;
  localparam int CW = 16;
  localparam int W  = 68;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b0;
  logic           clear_i = 1'b0;
  logic           start_i = 1'b0;
  logic [31:0]    base_addr_i = '0;
  logic [CW-1:0]  line_len_i = '0;
  logic [31:0]    line_stride_i = '0;
  logic [CW-1:0]  nb_lines_i = '0;
  logic           ready_start_o;
  logic           busy_o;
  logic           done_o;
  logic           stream_valid_i = 1'b0;
  logic           stream_ready_o;
  logic [DW-1:0]  stream_data_i = '0;
  logic [DW/8-1:0] stream_strb_i = '0;
  logic [NP-1:0]  tcdm_req_o;
  logic [NP-1:0]  tcdm_gnt_i;
  logic [NP*32-1:0] tcdm_add_o;
  logic [NP-1:0]  tcdm_wen_o;
  logic [NP*4-1:0] tcdm_be_o;
  logic [NP*32-1:0] tcdm_data_o;
`ifdef HWPE_STREAM_SINK_PERF_EN
  logic [31:0]    stall_cnt_o;
`endif

  hwpe_stream_sink_2d #(.DATA_WIDTH(DW), .NB_TCDM_PORTS(NP), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .line_len_i(line_len_i), .line_stride_i(line_stride_i),
    .nb_lines_i(nb_lines_i), .ready_start_o(ready_start_o), .busy_o(busy_o), .done_o(done_o),
    .stream_valid_i(stream_valid_i), .stream_ready_o(stream_ready_o),
    .stream_data_i(stream_data_i), .stream_strb_i(stream_strb_i),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o)
`ifdef HWPE_STREAM_SINK_PERF_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int req0_cyc = 0;
  int req1_cyc = 0;
  int busy_cyc = 0;
  int done_cnt = 0;
  int gnt_delay = 0;
  int hold1 = 0;

  // port 0 always grants; port 1 grants after gnt_delay refused request cycles
  assign tcdm_gnt_i = {(gnt_delay == 0) || (hold1 >= gnt_delay), 1'b1};

  always @(posedge clk_i) begin
    if (tcdm_req_o[1] && !tcdm_gnt_i[1]) hold1 <= hold1 + 1;
    else hold1 <= 0;
  end

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard side: every accepted lane write must match the head of exp_q
  always @(negedge clk_i) begin
    if (tcdm_req_o[0]) req0_cyc++;
    if (tcdm_req_o[1]) req1_cyc++;
    if (busy_o) busy_cyc++;
    if (done_o) done_cnt++;
    for (int i = 0; i < NP; i++) begin
      if (tcdm_req_o[i] && tcdm_gnt_i[i]) begin
        check_eq("write_wen", W'(tcdm_wen_o[i]), W'(0));
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write", W'(tcdm_add_o[32*i +: 32]), W'(0));
        end else begin
          check_eq($sformatf("write_lane%0d", i),
                   {tcdm_add_o[32*i +: 32], tcdm_be_o[4*i +: 4], tcdm_data_o[32*i +: 32]},
                   exp_q.pop_front());
        end
      end
    end
  end

  task automatic clear_counts();
    req0_cyc = 0; req1_cyc = 0; busy_cyc = 0; done_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic start_xfer(input logic [31:0] base, input int len, input logic [31:0] stride,
                            input int lines);
    base_addr_i   = base;
    line_len_i    = CW'(len);
    line_stride_i = stride;
    nb_lines_i    = CW'(lines);
    start_i       = 1'b1;
    step();
    start_i       = 1'b0;
  endtask

  task automatic drive_beat(input logic [63:0] data, input logic [7:0] strb,
                            input logic [31:0] addr, output int cycles);
    bit got;
    stream_valid_i = 1'b1;
    stream_data_i  = data;
    stream_strb_i  = strb;
    for (int i = 0; i < NP; i++)
      if (strb[4*i +: 4] != 4'h0)
        exp_q.push_back({addr + 32'(4 * i), strb[4*i +: 4], data[32*i +: 32]});
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 50) begin
      @(negedge clk_i);
      cycles++;
      if (stream_ready_o) got = 1'b1;
      step();
    end
    if (!got) check_eq("beat_timeout", W'(0), W'(1));
    stream_valid_i = 1'b0;
  endtask

  task automatic run_lines(input logic [31:0] base, input int len, input logic [31:0] stride,
                           input int lines, output int total);
    int c;
    total = 0;
    for (int l = 0; l < lines; l++)
      for (int b = 0; b < len; b++) begin
        drive_beat({$urandom, $urandom}, 8'hFF, base + 32'(l) * stride + 32'(b * 8), c);
        total += c;
      end
  endtask

  initial begin
    int tot;
    int c;
    logic [7:0] strb_tab [4];
    strb_tab[0] = 8'hFF; strb_tab[1] = 8'h0F; strb_tab[2] = 8'h00; strb_tab[3] = 8'h3C;

    rst_i = 1'b1;
    repeat (2) step();
    @(negedge clk_i);
    check_eq("rst_ready_start", W'(ready_start_o), W'(1));
    check_eq("rst_busy", W'(busy_o), W'(0));
    check_eq("rst_done", W'(done_o), W'(0));
    check_eq("rst_req", W'(tcdm_req_o), W'(0));
    step();
    rst_i = 1'b0;
    step();

    // two lines of four full beats at full throughput
    clear_counts();
    start_xfer(32'h1000, 4, 32'h100, 2);
    run_lines(32'h1000, 4, 32'h100, 2, tot);
    check_eq("a_beat_cycles", W'(tot), W'(8));
    @(negedge clk_i);
    check_eq("a_done_pulse", W'(done_o), W'(1));
    check_eq("a_idle_after", W'(ready_start_o), W'(1));
    repeat (3) step();
    check_eq("a_busy_cycles", W'(busy_cyc), W'(8));
    check_eq("a_done_count", W'(done_cnt), W'(1));
    check_eq("a_queue_empty", W'(exp_q.size()), W'(0));

    // port 1 grant held back three cycles
    clear_counts();
    gnt_delay = 3;
    start_xfer(32'h2000, 1, 32'h0, 1);
    drive_beat({$urandom, $urandom}, 8'hFF, 32'h2000, c);
    gnt_delay = 0;
    check_eq("b_beat_cycles", W'(c), W'(4));
    check_eq("b_req0_cycles", W'(req0_cyc), W'(1));
    check_eq("b_req1_cycles", W'(req1_cyc), W'(4));
    repeat (2) step();
    check_eq("b_done_count", W'(done_cnt), W'(1));

    // partial and empty strobes
    clear_counts();
    start_xfer(32'h3000, 4, 32'h40, 1);
    tot = 0;
    for (int b = 0; b < 4; b++) begin
      drive_beat({$urandom, $urandom}, strb_tab[b], 32'h3000 + 32'(b * 8), c);
      tot += c;
    end
    repeat (2) step();
    check_eq("c_beat_cycles", W'(tot), W'(4));
    check_eq("c_req0_cycles", W'(req0_cyc), W'(3));
    check_eq("c_req1_cycles", W'(req1_cyc), W'(2));
    check_eq("c_done_count", W'(done_cnt), W'(1));

    // zero length, then zero lines
    for (int k = 0; k < 2; k++) begin
      clear_counts();
      stream_valid_i = 1'b1;
      stream_strb_i  = 8'hFF;
      start_xfer(32'h4000, (k == 0) ? 0 : 3, 32'h10, (k == 0) ? 3 : 0);
      @(negedge clk_i);
      check_eq("d_busy", W'(busy_o), W'(1));
      check_eq("d_no_done_yet", W'(done_o), W'(0));
      step();
      @(negedge clk_i);
      check_eq("d_done", W'(done_o), W'(1));
      check_eq("d_idle", W'(busy_o), W'(0));
      step();
      @(negedge clk_i);
      check_eq("d_done_low", W'(done_o), W'(0));
      check_eq("d_no_req", W'(req0_cyc + req1_cyc), W'(0));
      stream_valid_i = 1'b0;
      step();
    end

    // synchronous clear during beat 3, then clear beats start, then restart
    clear_counts();
    start_xfer(32'h5000, 4, 32'h100, 2);
    run_lines(32'h5000, 3, 32'h0, 1, tot);
    clear_i = 1'b1;
    @(negedge clk_i);
    check_eq("e_busy_before_clear", W'(busy_o), W'(1));
    step();
    clear_i = 1'b0;
    @(negedge clk_i);
    check_eq("e_cleared_idle", W'(ready_start_o), W'(1));
    check_eq("e_cleared_add", W'(tcdm_add_o), W'(0));
    step();
    clear_i = 1'b1;
    start_xfer(32'h5800, 2, 32'h0, 1);
    clear_i = 1'b0;
    @(negedge clk_i);
    check_eq("e_clear_beats_start", W'(busy_o), W'(0));
    repeat (2) step();
    check_eq("e_no_done", W'(done_cnt), W'(0));
    start_xfer(32'h6000, 2, 32'h20, 1);
    run_lines(32'h6000, 2, 32'h20, 1, tot);
    repeat (2) step();
    check_eq("e_restart_done", W'(done_cnt), W'(1));

    // asynchronous reset during beat 3, then restart
    clear_counts();
    start_xfer(32'h7000, 4, 32'h100, 2);
    run_lines(32'h7000, 3, 32'h0, 1, tot);
    rst_i = 1'b1;
    #1;
    check_eq("f_rst_busy", W'(busy_o), W'(0));
    check_eq("f_rst_ready", W'(ready_start_o), W'(1));
    check_eq("f_rst_add", W'(tcdm_add_o), W'(0));
    step();
    rst_i = 1'b0;
    step();
    check_eq("f_no_done", W'(done_cnt), W'(0));
    start_xfer(32'h8000, 2, 32'h40, 2);
    run_lines(32'h8000, 2, 32'h40, 2, tot);
    repeat (2) step();
    check_eq("f_restart_done", W'(done_cnt), W'(1));

`ifdef HWPE_STREAM_SINK_PERF_EN
    // 3 + 2 stalled cycles over two beats
    start_xfer(32'h9000, 2, 32'h0, 1);
    gnt_delay = 3;
    drive_beat({$urandom, $urandom}, 8'hFF, 32'h9000, c);
    gnt_delay = 2;
    drive_beat({$urandom, $urandom}, 8'hFF, 32'h9008, c);
    gnt_delay = 0;
    @(negedge clk_i);
    check_eq("g_stall_cnt", W'(stall_cnt_o), W'(5));
    step();
`endif

    check_eq("final_queue_empty", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
